fir_decim_framer: RTL and testbench

Decimating frame collector on the output side of the FIR low-pass stage. Each valid filtered sample is counted, every DECIM-th one is kept, and the kept samples are packed into FRAME_LEN-sample frames in a two-bank (ping-pong) buffer. Completed frames are streamed to the downstream spectral stage over a ready/valid handshake. Input samples are never back-pressured: if both banks are full, kept samples are dropped and a sticky overflow flag is set.

---
 rtl/fir_decim_framer.sv | 159 +++++++++++++++
 tb/tb_fir_decim_framer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_framer.sv
// Decimating frame collector: keeps every DECIM-th valid sample, packs kept samples
// into FRAME_LEN-sample frames across two ping-pong banks and streams full frames out.
module fir_decim_framer #(
    parameter int DECIM     = 4,
    parameter int FRAME_LEN = 64,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [15:0]   in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [15:0]   out_data,
    output logic [AW-1:0]        out_index,
    output logic                 out_last,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1'b1);
    localparam logic [PW-1:0] PH_LAST   = PW'(DECIM - 1);
    localparam logic [PW-1:0] PH_ONE    = PW'(1'b1);

    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

    logic signed [15:0] mem_r [2][FRAME_LEN];
    logic [PW-1:0]      ph_r;
    logic               wr_bank_r, rd_bank_r;
    logic [AW-1:0]      wr_addr_r, rd_addr_r;
    logic [1:0]         full_r;
    state_t             state_r;
    logic               out_valid_r, out_last_r, overflow_r;
    logic signed [15:0] out_data_r;
    logic [AW-1:0]      out_index_r;

    logic               keep_s, wr_en_s, wr_done_s, drop_s, hs_s, rd_done_s;
    logic [1:0]         full_nxt_s;
    state_t             state_nxt_s;
    logic               rd_bank_nxt_s;
    logic [AW-1:0]      rd_addr_nxt_s;
    logic               out_valid_s, out_last_s, overflow_s;
    logic signed [15:0] out_data_s;
    logic [AW-1:0]      out_index_s;

    // Writer side decode: keep/write/drop decisions for the current input strobe
    always_comb begin
        keep_s    = in_valid && (ph_r == {PW{1'b0}});
        wr_en_s   = keep_s && !full_r[wr_bank_r];
        drop_s    = keep_s && full_r[wr_bank_r];
        wr_done_s = wr_en_s && (wr_addr_r == LAST_ADDR);
    end

    // Reader next-state; full flags are looked ahead so a bank filled on the
    // same edge as the last read keeps the stream going without a bubble
    always_comb begin
        hs_s          = (state_r == STREAM) && out_ready;
        rd_done_s     = hs_s && (rd_addr_r == LAST_ADDR);
        full_nxt_s[0] = (full_r[0] | (wr_done_s && !wr_bank_r)) & ~(rd_done_s && !rd_bank_r);
        full_nxt_s[1] = (full_r[1] | (wr_done_s &&  wr_bank_r)) & ~(rd_done_s &&  rd_bank_r);
        state_nxt_s   = state_r;
        rd_bank_nxt_s = rd_bank_r;
        rd_addr_nxt_s = rd_addr_r;
        case (state_r)
            IDLE: begin
                if (full_r[rd_bank_r]) begin
                    state_nxt_s   = STREAM;
                    rd_addr_nxt_s = {AW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (rd_done_s) begin
                    rd_bank_nxt_s = ~rd_bank_r;
                    rd_addr_nxt_s = {AW{1'b0}};
                    state_nxt_s   = full_nxt_s[~rd_bank_r] ? STREAM : IDLE;
                end else if (hs_s) begin
                    rd_addr_nxt_s = rd_addr_r + ADDR_ONE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output values for the next cycle; data holds while idle
    always_comb begin
        out_valid_s = (state_nxt_s == STREAM);
        out_index_s = rd_addr_nxt_s;
        out_last_s  = (rd_addr_nxt_s == LAST_ADDR);
        if (out_valid_s) begin
            out_data_s = mem_r[rd_bank_nxt_s][rd_addr_nxt_s];
        end else begin
            out_data_s = out_data_r;
        end
        if (drop_s) begin
            overflow_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
    end

    // Sample storage; contents are don't-care until a bank is written
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_bank_r][wr_addr_r] <= in_data;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_r        <= {PW{1'b0}};
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_addr_r   <= {AW{1'b0}};
            rd_addr_r   <= {AW{1'b0}};
            full_r      <= 2'b00;
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'sd0;
            out_index_r <= {AW{1'b0}};
            out_last_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (in_valid) begin
                ph_r <= (ph_r == PH_LAST) ? {PW{1'b0}} : ph_r + PH_ONE;
            end
            if (wr_en_s) begin
                wr_addr_r <= wr_done_s ? {AW{1'b0}} : wr_addr_r + ADDR_ONE;
            end
            if (wr_done_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            full_r      <= full_nxt_s;
            state_r     <= state_nxt_s;
            rd_bank_r   <= rd_bank_nxt_s;
            rd_addr_r   <= rd_addr_nxt_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_index_r <= out_index_s;
            out_last_r  <= out_last_s;
            overflow_r  <= overflow_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = out_index_r;
    assign out_last  = out_last_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_fir_decim_framer.sv
// Directed bench: a DECIM=4 instance (a_*) and a DECIM=1 instance (b_*), both FRAME_LEN=8.
module tb_fir_decim_framer;
    localparam int FL = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic a_in_valid = 1'b0, a_out_ready = 1'b0, a_clr_ovf = 1'b0;
    logic signed [15:0] a_in_data = 16'sd0;
    logic a_out_valid, a_out_last, a_overflow;
    logic signed [15:0] a_out_data;
    logic [AW-1:0] a_out_index;

    logic b_in_valid = 1'b0, b_out_ready = 1'b0, b_clr_ovf = 1'b0;
    logic signed [15:0] b_in_data = 16'sd0;
    logic b_out_valid, b_out_last, b_overflow;
    logic signed [15:0] b_out_data;
    logic [AW-1:0] b_out_index;

    fir_decim_framer #(.DECIM(4), .FRAME_LEN(FL)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_index(a_out_index), .out_last(a_out_last), .overflow(a_overflow),
        .clr_ovf(a_clr_ovf));

    fir_decim_framer #(.DECIM(1), .FRAME_LEN(FL)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_index(b_out_index), .out_last(b_out_last), .overflow(b_overflow),
        .clr_ovf(b_clr_ovf));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        vin;
        logic [15:0] din;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ei;
        logic        el;
    } vec_t;
    vec_t tbl [40];

    function automatic logic [31:0] beat(input logic v, input logic [15:0] d,
                                         input logic [2:0] i, input logic l);
        return {11'd0, v, d, i, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_clr_ovf = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_clr_ovf = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    // Reads n beats from instance b with out_ready high; data base+k, index k%8
    task automatic expect_frame_b(input string name, input int n, input int base);
        int k;
        k = 0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int c = 0; c < n + 40 && k < n; c++) begin
            if (b_out_valid) begin
                check(name, beat(b_out_valid, b_out_data, b_out_index, b_out_last),
                      beat(1'b1, 16'(base + k), 3'(k % FL), (k % FL) == FL - 1));
                k++;
            end
            step();
        end
        check({name, "_count"}, 32'(k), 32'(n));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic signed [15:0] q[$];
        logic [31:0] held;
        logic [15:0] e;
        logic stall;
        int mph, eidx, k, gaps;
        bit started;

        for (int i = 0; i < 40; i++) begin
            tbl[i].vin = (i < 32);
            tbl[i].din = 16'(i);
            tbl[i].ev  = (i >= 29 && i <= 36);
            tbl[i].ed  = tbl[i].ev ? 16'(4 * (i - 29)) : 16'd0;
            tbl[i].ei  = tbl[i].ev ? 3'(i - 29) : 3'd0;
            tbl[i].el  = (i == 36);
        end

        // Reset state
        do_reset();
        check("reset_a", beat(a_out_valid, a_out_data, a_out_index, a_out_last) | {31'd0, a_overflow}, 32'd0);
        check("reset_b", beat(b_out_valid, b_out_data, b_out_index, b_out_last) | {31'd0, b_overflow}, 32'd0);

        // Decimation, table-driven
        a_out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a_in_valid = tbl[i].vin;
            a_in_data  = tbl[i].din;
            step();
            if (tbl[i].ev)
                check("decim", beat(a_out_valid, a_out_data, a_out_index, a_out_last),
                      beat(1'b1, tbl[i].ed, tbl[i].ei, tbl[i].el));
            else
                check("decim_idle", beat(a_out_valid, 16'd0, 3'd0, a_out_last), 32'd0);
        end
        a_in_valid = 1'b0;

        // Back-pressure with a scoreboard, ready pattern 1,0,0
        mph = 0; eidx = 0;
        for (int c = 0; c < 400 && (c < 64 || q.size() > 0); c++) begin
            a_in_valid = (c < 64);
            a_in_data  = 16'(100 + c);
            if (c < 64) begin
                if (mph == 0) q.push_back(16'(100 + c));
                mph = (mph + 1) % 4;
            end
            a_out_ready = (c % 3 == 0);
            stall = a_out_valid && !a_out_ready;
            held  = beat(a_out_valid, a_out_data, a_out_index, a_out_last);
            if (a_out_valid && a_out_ready) begin
                e = (q.size() > 0) ? q.pop_front() : 16'hdead;
                check("bp_beat", held, beat(1'b1, e, 3'(eidx), eidx == FL - 1));
                eidx = (eidx + 1) % FL;
            end
            step();
            if (stall) check("bp_hold", beat(a_out_valid, a_out_data, a_out_index, a_out_last), held);
        end
        a_in_valid = 1'b0;
        check("bp_drained", 32'(q.size()), 32'd0);
        check("bp_no_ovf", {31'd0, a_overflow}, 32'd0);

        // Ping-pong, no bubble, negative samples
        k = 0; gaps = 0; started = 1'b0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            b_in_valid = (c < 16);
            b_in_data  = 16'(-32768 + c);
            if (b_out_valid) begin
                started = 1'b1;
                if (k < 16)
                    check("pp_beat", beat(b_out_valid, b_out_data, b_out_index, b_out_last),
                          beat(1'b1, 16'(-32768 + k), 3'(k % FL), (k % FL) == FL - 1));
                k++;
            end else if (started && k < 16) begin
                gaps++;
            end
            step();
        end
        b_in_valid = 1'b0;
        check("pp_gaps", 32'(gaps), 32'd0);
        check("pp_count", 32'(k), 32'd16);

        // Overflow with the reader stalled
        do_reset();
        for (int c = 0; c < 20; c++) begin
            b_in_valid = 1'b1;
            b_in_data  = 16'(100 + c);
            step();
            check("ovf_set", {31'd0, b_overflow}, 32'(c >= 16));
        end
        b_in_valid = 1'b0;
        expect_frame_b("ovf_drain", 16, 100);
        repeat (3) step();
        check("ovf_nomore", {31'd0, b_out_valid}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            b_in_valid = 1'b1;
            b_in_data  = 16'(200 + c);
            step();
        end
        expect_frame_b("ovf_clean", 8, 200);
        check("ovf_sticky", {31'd0, b_overflow}, 32'd1);
        b_clr_ovf = 1'b1;
        step();
        b_clr_ovf = 1'b0;
        check("ovf_clr", {31'd0, b_overflow}, 32'd0);
        b_out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            b_in_valid = 1'b1;
            b_in_data  = 16'(600 + c);
            step();
        end
        check("ovf_full_noset", {31'd0, b_overflow}, 32'd0);
        b_in_data = 16'(616);
        b_clr_ovf = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_clr_ovf  = 1'b0;
        check("ovf_set_wins", {31'd0, b_overflow}, 32'd1);
        expect_frame_b("ovf_refill", 16, 600);

        // Reset in the middle of streaming and of filling the other bank
        b_out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            b_in_valid = 1'b1;
            b_in_data  = (c < 8) ? 16'(300 + c) : 16'(400 + c - 8);
            step();
        end
        check("rst_pre_valid", {31'd0, b_out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async", beat(b_out_valid, b_out_data, b_out_index, b_out_last) | {31'd0, b_overflow}, 32'd0);
        b_in_valid = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            b_in_valid = 1'b1;
            b_in_data  = 16'(500 + c);
            step();
        end
        expect_frame_b("rst_post", 8, 500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
